// File: rtl/k6502_oam_dma.sv
// ============================================================================
// Module   : k6502_oam_dma
// Purpose  : NES sprite DMA. Halts the CPU and copies one page to OAMDATA.
// Revision : 1.0
// ============================================================================
`default_nettype none

module k6502_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter int          COUNT        = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_rw,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_d,
    output logic        dma_rw,
    input  logic [7:0]  bus_din
);

    localparam logic [7:0] c_LAST = 8'(COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic        r_cyc_odd;
    logic        r_rdy;
    logic        r_active;
    logic [15:0] r_dma_a;
    logic [7:0]  r_dma_d;
    logic        r_dma_rw;

    logic [7:0]  w_page_nxt;
    logic [7:0]  w_idx_nxt;
    logic [7:0]  w_d_nxt;
    logic        w_rdy_nxt;
    logic        w_active_nxt;
    logic [15:0] w_a_nxt;
    logic        w_rw_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_idx_nxt   = r_idx;
        w_d_nxt     = r_dma_d;
        case (r_state)
            S_IDLE: begin
                if (!cpu_rw && (cpu_a == DMA_REG_ADDR)) begin
                    w_page_nxt  = cpu_d;
                    w_idx_nxt   = 8'h00;
                    w_state_nxt = S_HALT;
                end
            end
            // Reads must land on even cycles, so an even HALT needs one pad cycle.
            S_HALT:  w_state_nxt = r_cyc_odd ? S_READ : S_ALIGN;
            S_ALIGN: w_state_nxt = S_READ;
            S_READ: begin
                w_d_nxt     = bus_din;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (r_idx != c_LAST) begin
                    w_idx_nxt   = r_idx + 8'd1;
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state and registered below.
        w_rdy_nxt    = 1'b1;
        w_active_nxt = 1'b0;
        w_a_nxt      = 16'h0000;
        w_rw_nxt     = 1'b1;
        case (w_state_nxt)
            S_HALT, S_ALIGN, S_READ: begin
                w_rdy_nxt    = 1'b0;
                w_active_nxt = 1'b1;
                w_a_nxt      = {w_page_nxt, w_idx_nxt};
            end
            S_WRITE: begin
                w_rdy_nxt    = 1'b0;
                w_active_nxt = 1'b1;
                w_a_nxt      = DEST_ADDR;
                w_rw_nxt     = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_page    <= 8'h00;
            r_idx     <= 8'h00;
            r_cyc_odd <= 1'b0;
            r_rdy     <= 1'b1;
            r_active  <= 1'b0;
            r_dma_a   <= 16'h0000;
            r_dma_d   <= 8'h00;
            r_dma_rw  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_page    <= w_page_nxt;
            r_idx     <= w_idx_nxt;
            r_cyc_odd <= ~r_cyc_odd;
            r_rdy     <= w_rdy_nxt;
            r_active  <= w_active_nxt;
            r_dma_a   <= w_a_nxt;
            r_dma_d   <= w_d_nxt;
            r_dma_rw  <= w_rw_nxt;
        end
    end

    assign rdy        = r_rdy;
    assign dma_active = r_active;
    assign dma_a      = r_dma_a;
    assign dma_d      = r_dma_d;
    assign dma_rw     = r_dma_rw;

endmodule

`default_nettype wire
